// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the I2S transmit path.
//   pcm16_t          signed 16-bit PCM sample
//   I2S_SLOTS        BCLK periods per I2S frame
//   I2S_BITS_PER_CH  bits serialized per channel
//   FIFO_W           sample FIFO entry width (32 when AUDIO_I2S_TX_STEREO_EN
//                    is defined, otherwise 16)
// -----------------------------------------------------------------------------
package audio_pkg;

    typedef logic signed [15:0] pcm16_t;

    localparam int unsigned I2S_SLOTS       = 32;
    localparam int unsigned I2S_BITS_PER_CH = 16;
    localparam int unsigned I2S_FRAME_W     = 2 * I2S_BITS_PER_CH;
    localparam int unsigned SLOT_W          = $clog2(I2S_SLOTS);

`ifdef AUDIO_I2S_TX_STEREO_EN
    localparam int unsigned FIFO_W = 2 * I2S_BITS_PER_CH;
`else
    localparam int unsigned FIFO_W = I2S_BITS_PER_CH;
`endif

    // Frame layout is {L, R}; serialization walks it MSB first.
    function automatic logic [I2S_FRAME_W-1:0] make_frame(input pcm16_t l, input pcm16_t r);
        return {l, r};
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx_if
// Mono/stereo sample stream from the mixer into audio_i2s_tx.
//   sample_valid  one-cycle write strobe
//   sample        signed PCM, left or mono
//   sample_r      signed PCM, right (only with AUDIO_I2S_TX_STEREO_EN)
// Modports: master = sample producer, slave = audio_i2s_tx.
// -----------------------------------------------------------------------------
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic   sample_valid;
    pcm16_t sample;
`ifdef AUDIO_I2S_TX_STEREO_EN
    pcm16_t sample_r;
`endif

    modport master (
`ifdef AUDIO_I2S_TX_STEREO_EN
        output sample_r,
`endif
        output sample_valid,
        output sample
    );

    modport slave (
`ifdef AUDIO_I2S_TX_STEREO_EN
        input sample_r,
`endif
        input sample_valid,
        input sample
    );

endinterface

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous first-word fall-through FIFO.
//   clk, rst_n    clock, asynchronous active-low reset (flushes the FIFO)
//   wr_en/wr_data write request; accepted when not full, or when full and a
//                 read happens in the same cycle
//   rd_en         pop request; ignored when empty
//   rd_data       head entry, valid whenever empty is low
//   full, empty   status from the registered level
//   level         registered occupancy
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_pop;
    logic do_push;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Buffers PCM samples and serializes them as Philips I2S frames
// (32 BCLK per frame, 16 bits per channel, MSB first, one-BCLK data delay).
// Optional stereo build: define AUDIO_I2S_TX_STEREO_EN to add sample_r to the
// stream interface; otherwise the mono sample is sent on both channels.
//   clk          system clock
//   reset        asynchronous active-low reset
//   s_if         sample stream (audio_i2s_tx_if.slave)
//   i2s_bclk     bit clock, period 2*BCLK_DIV clk cycles
//   i2s_lrck     word select, 0 = left, 1 = right
//   i2s_sdata    serial data, changes on BCLK falling edges
//   fifo_level   registered FIFO occupancy
//   underrun     one-cycle pulse: frame started with the FIFO empty
//   overflow     one-cycle pulse: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV   = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    audio_i2s_tx_if.slave                s_if,
    output logic                         i2s_bclk,
    output logic                         i2s_lrck,
    output logic                         i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    output logic                         overflow
);

    logic [7:0]             div_q, div_d;
    logic                   bclk_q, bclk_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic                   sdata_q, sdata_d;
    logic [I2S_FRAME_W-1:0] shift_q, shift_d;
    logic [I2S_FRAME_W-1:0] held_q, held_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;

    logic                   div_tc;
    logic                   bclk_fall;
    logic                   frame_start;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_W-1:0]      fifo_wr_data;
    logic [FIFO_W-1:0]      fifo_rd_data;
    logic [I2S_FRAME_W-1:0] new_frame;

    assign div_tc      = (div_q == 8'(BCLK_DIV - 1));
    assign bclk_fall   = div_tc && bclk_q;
    assign frame_start = bclk_fall && (slot_q == '1);
    // Pop only at a frame boundary; an empty FIFO at that moment is an underrun
    // even if a write lands in the same cycle.
    assign pop         = frame_start && !fifo_empty;

`ifdef AUDIO_I2S_TX_STEREO_EN
    assign fifo_wr_data = {s_if.sample, s_if.sample_r};
    assign new_frame    = make_frame(fifo_rd_data[FIFO_W-1 -: 16], fifo_rd_data[15:0]);
`else
    assign fifo_wr_data = s_if.sample;
    assign new_frame    = make_frame(fifo_rd_data, fifo_rd_data);
`endif

    sample_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (s_if.sample_valid),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        div_d      = div_tc ? '0 : div_q + 8'd1;
        bclk_d     = div_tc ? ~bclk_q : bclk_q;
        slot_d     = slot_q;
        sdata_d    = sdata_q;
        shift_d    = shift_q;
        held_d     = held_q;
        underrun_d = 1'b0;
        overflow_d = s_if.sample_valid && fifo_full && !pop;

        if (bclk_fall) begin
            slot_d  = slot_q + 1'b1;
            // The MSB shifted out on the slot-0 entry is R[0] of the frame
            // just finished, which gives the one-BCLK data delay for free.
            sdata_d = shift_q[I2S_FRAME_W-1];
            shift_d = {shift_q[I2S_FRAME_W-2:0], 1'b0};
            if (frame_start) begin
                if (pop) begin
                    held_d  = new_frame;
                    shift_d = new_frame;
                end else begin
                    shift_d    = held_q;
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b1;
            slot_q     <= '1;
            sdata_q    <= 1'b0;
            shift_q    <= '0;
            held_q     <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            sdata_q    <= sdata_d;
            shift_q    <= shift_d;
            held_q     <= held_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrck  = slot_q[SLOT_W-1];
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
// Self-checking bench for audio_i2s_tx with BCLK_DIV=2, FIFO_DEPTH=4.
// Edge e counts rising clk edges after reset release; with DIV=2 slot k of
// frame f is presented just after edge 128*f + 2 + 4*k.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;

    localparam int unsigned DIV   = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [15:0] s;
        logic [15:0] sr;
    } pair_t;

    typedef struct {
        pair_t       p;
        logic [31:0] exp_mono;
        logic [31:0] exp_st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i2s_bclk, i2s_lrck, i2s_sdata;
    logic [2:0] fifo_level;
    logic       underrun, overflow;

    int unsigned ecnt;
    int unsigned underrun_cnt;
    int unsigned overflow_cnt;
    int unsigned n_chk;
    int unsigned n_pass;

    audio_i2s_tx_if s_if ();

    audio_i2s_tx #(
        .BCLK_DIV   (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_if       (s_if),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdata  (i2s_sdata),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic int unsigned edge_of(input int unsigned f, input int unsigned k);
        return 64 * DIV * f + DIV + 2 * DIV * k;
    endfunction

    function automatic logic [31:0] exp_word(input pair_t p);
`ifdef AUDIO_I2S_TX_STEREO_EN
        return {p.s, p.sr};
`else
        return {p.s, p.s};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        if (underrun === 1'b1) underrun_cnt++;
        if (overflow === 1'b1) overflow_cnt++;
    endtask

    task automatic run_to(input int unsigned e);
        while (ecnt < e) tick();
    endtask

    task automatic push(input pair_t p);
        s_if.sample_valid = 1'b1;
        s_if.sample       = p.s;
`ifdef AUDIO_I2S_TX_STEREO_EN
        s_if.sample_r     = p.sr;
`endif
        tick();
        s_if.sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        s_if.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ecnt = 0;
        underrun_cnt = 0;
        overflow_cnt = 0;
    endtask

    // Collects slots 1..31 of frame f plus slot 0 of frame f+1: {L, R}.
    task automatic capture_frame(input int unsigned f, output logic [31:0] w);
        w = '0;
        for (int unsigned k = 1; k <= 32; k++) begin
            run_to(edge_of(f, k));
            w = {w[30:0], i2s_sdata};
        end
    endtask

    // Idle stream (empty FIFO, zero held frame) timing checked every cycle.
    task automatic check_idle(input int unsigned n);
        int unsigned slot;
        logic        exp_ur;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            slot   = (ecnt < DIV) ? 31 : ((ecnt - DIV) / (2 * DIV)) % 32;
            exp_ur = (ecnt >= DIV) && (((ecnt - DIV) % (64 * DIV)) == 0);
            check("idle_bclk", 32'(i2s_bclk), 32'(((ecnt / DIV) + 1) % 2));
            check("idle_lrck", 32'(i2s_lrck), 32'(slot / 16));
            check("idle_sdata", 32'(i2s_sdata), 32'd0);
            check("idle_underrun", 32'(underrun), 32'(exp_ur));
        end
    endtask

    vec_t        tbl [6];
    pair_t       seq [5];
    logic [31:0] w;

    initial begin
        tbl[0] = '{'{16'h8001, 16'h7FFE}, 32'h8001_8001, 32'h8001_7FFE};
        tbl[1] = '{'{16'h1234, 16'h5678}, 32'h1234_1234, 32'h1234_5678};
        tbl[2] = '{'{16'hFFFF, 16'h0000}, 32'hFFFF_FFFF, 32'hFFFF_0000};
        tbl[3] = '{'{16'h0000, 16'hFFFF}, 32'h0000_0000, 32'h0000_FFFF};
        tbl[4] = '{'{16'h00FF, 16'hFF00}, 32'h00FF_00FF, 32'h00FF_FF00};
        tbl[5] = '{'{16'hA5C3, 16'h3C5A}, 32'hA5C3_A5C3, 32'hA5C3_3C5A};

        n_chk = 0;
        n_pass = 0;
        ecnt = 0;
        s_if.sample_valid = 1'b0;
        s_if.sample = '0;
`ifdef AUDIO_I2S_TX_STEREO_EN
        s_if.sample_r = '0;
`endif

        // Reset values, applied without a clock edge.
        #1 reset = 1'b0;
        #1;
        check("rst_bclk", 32'(i2s_bclk), 32'd1);
        check("rst_lrck", 32'(i2s_lrck), 32'd1);
        check("rst_sdata", 32'(i2s_sdata), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Idle timing after reset release.
        do_reset();
        check_idle(260);

        // Single sample per vector, pushed before the first slot-0 entry.
        for (int unsigned i = 0; i < 6; i++) begin
            do_reset();
            push(tbl[i].p);
            check("vec_level_push", 32'(fifo_level), 32'd1);
            run_to(edge_of(0, 0));
            check("vec_slot0_sdata", 32'(i2s_sdata), 32'd0);
            check("vec_slot0_lrck", 32'(i2s_lrck), 32'd0);
            check("vec_level_pop", 32'(fifo_level), 32'd0);
            check("vec_no_underrun", 32'(underrun), 32'd0);
            capture_frame(0, w);
`ifdef AUDIO_I2S_TX_STEREO_EN
            check("vec_frame", w, tbl[i].exp_st);
`else
            check("vec_frame", w, tbl[i].exp_mono);
`endif
            check("vec_underrun_cnt", underrun_cnt, 32'd1);
        end

        // Underrun hold: one sample, then three frames of repeats.
        do_reset();
        seq[0] = '{16'h1234, 16'hEDCB};
        push(seq[0]);
        for (int unsigned f = 0; f < 3; f++) begin
            capture_frame(f, w);
            check("hold_frame", w, exp_word(seq[0]));
        end
        check("hold_underrun_cnt", underrun_cnt, 32'd3);

        // Overflow: five back-to-back writes mid-frame.
        do_reset();
        run_to(20);
        seq[0] = '{16'h1111, 16'hEEEE};
        seq[1] = '{16'h2222, 16'hDDDD};
        seq[2] = '{16'h3333, 16'hCCCC};
        seq[3] = '{16'h4444, 16'hBBBB};
        seq[4] = '{16'h5555, 16'hAAAA};
        for (int unsigned i = 0; i < 5; i++) begin
            push(seq[i]);
            check("ovf_level", 32'(fifo_level), (i < 4) ? i + 1 : 32'd4);
        end
        check("ovf_pulse", 32'(overflow), 32'd1);
        tick();
        check("ovf_pulse_end", 32'(overflow), 32'd0);
        check("ovf_cnt", overflow_cnt, 32'd1);
        for (int unsigned f = 1; f <= 4; f++) begin
            capture_frame(f, w);
            check("ovf_frame", w, exp_word(seq[f-1]));
        end
        capture_frame(5, w);
        check("ovf_dropped", w, exp_word(seq[3]));

        // Write in the pop cycle while full.
        do_reset();
        run_to(9);
        seq[0] = '{16'hB001, 16'h1B00};
        seq[1] = '{16'hB002, 16'h2B00};
        seq[2] = '{16'hB003, 16'h3B00};
        seq[3] = '{16'hB004, 16'h4B00};
        seq[4] = '{16'hB005, 16'h5B00};
        for (int unsigned i = 0; i < 4; i++) push(seq[i]);
        check("full_level", 32'(fifo_level), 32'd4);
        run_to(edge_of(1, 0) - 1);
        push(seq[4]);
        check("full_pop_level", 32'(fifo_level), 32'd4);
        check("full_pop_no_ovf", 32'(overflow), 32'd0);
        tick();
        check("full_pop_ovf_cnt", overflow_cnt, 32'd0);
        for (int unsigned f = 1; f <= 5; f++) begin
            capture_frame(f, w);
            check("full_pop_frame", w, exp_word(seq[f-1]));
        end

        // Write in the pop cycle while empty: pop sees empty, write kept.
        do_reset();
        tick();
        seq[0] = '{16'hC0DE, 16'h0DEC};
        push(seq[0]);
        check("empty_pop_underrun", 32'(underrun), 32'd1);
        check("empty_pop_level", 32'(fifo_level), 32'd1);
        capture_frame(0, w);
        check("empty_pop_frame0", w, 32'd0);
        capture_frame(1, w);
        check("empty_pop_frame1", w, exp_word(seq[0]));

        // Asynchronous reset at slot 9.
        do_reset();
        seq[0] = '{16'hFFFF, 16'hFFFF};
        seq[1] = '{16'h5555, 16'h5555};
        push(seq[0]);
        push(seq[1]);
        check("arst_pre_level", 32'(fifo_level), 32'd1);
        run_to(edge_of(0, 9));
        check("arst_pre_sdata", 32'(i2s_sdata), 32'd1);
        check("arst_pre_bclk", 32'(i2s_bclk), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("arst_bclk", 32'(i2s_bclk), 32'd1);
        check("arst_lrck", 32'(i2s_lrck), 32'd1);
        check("arst_sdata", 32'(i2s_sdata), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        do_reset();
        check_idle(260);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Output-side consumer of the mixer's mono sample stream.
- Accepts signed 16-bit PCM samples on a single-cycle strobe and buffers them in a small FIFO.
- Serializes each sample as a standard Philips I2S frame: 32 BCLK per frame, 16 bits per channel, MSB first, one-BCLK data delay after each LRCK edge.
- Drives an external DAC/HDMI audio path; mono build duplicates the sample to both channels.

Parameters:
- BCLK_DIV, 8: clk cycles per BCLK half-period; legal range 2..255.
- FIFO_DEPTH, 4: sample FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; sample is written when high.
- sample  in  16  signed PCM (left, or mono).
- i2s_bclk  out  1  serial bit clock.
- i2s_lrck  out  1  word select: 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  out  1  one-cycle pulse; a frame started with the FIFO empty.
- overflow  out  1  one-cycle pulse; a write was dropped because the FIFO was full.

Behaviour:
- Reset values while reset is low, applied asynchronously: i2s_bclk=1, i2s_lrck=1, i2s_sdata=0, fifo_level=0, underrun=0, overflow=0, slot counter=31, divider=0, shift register=0, held frame=0.
- Divider: counts 0..BCLK_DIV-1. At terminal count, i2s_bclk toggles and the divider returns to 0.
- The first BCLK falling edge occurs BCLK_DIV cycles after reset release.
- All serial outputs change only on the clk cycle in which BCLK falls. The DAC samples on the rising edge.
- Slot counter (5 bit) increments on each BCLK falling edge and wraps 31 to 0.
- LRCK: i2s_lrck = slot[4].
- Frame load on entry to slot 0:
  - FIFO non-empty: pop one entry and load frame {L,R}.
  - FIFO empty: reload the previous frame unchanged and pulse underrun for exactly one cycle.
  - Mono build: L = R = popped sample.
- Data mapping by slot k:
  - k = 0: R[0] of the previous frame.
  - k = 1..16: L[16-k].
  - k = 17..31: R[32-k].
- Frame rate = clk / (64 * BCLK_DIV).
- FIFO: synchronous, first-word fall-through.
  - Write when sample_valid=1 and not full.
  - sample_valid while full: data dropped, FIFO contents unchanged, overflow pulses in the following cycle.
  - Write and pop in the same cycle: both occur; level unchanged. When full, the pop frees space so the write is accepted.
  - Write and pop in the same cycle when empty: the pop sees empty (underrun, previous frame reused) and the write is accepted.
- Arithmetic: none on data. Samples pass bit-exact; no truncation or sign extension.
- fifo_level is registered and updates one cycle after a push or pop.
- Reset mid-frame: outputs return to reset values immediately; the FIFO is flushed.

Optional Feature:
- Macro: AUDIO_I2S_TX_STEREO_EN.
- Defined: adds input sample_r (16 bit, signed), captured with the same sample_valid strobe. FIFO width becomes 32; L = sample, R = sample_r.
- Undefined: no sample_r port; FIFO width 16; R = L.
- Timing is identical in both builds.

Decomposition:
- Package audio_pkg:
  - typedef pcm16_t (logic signed [15:0]).
  - localparam I2S_SLOTS = 32.
  - localparam I2S_BITS_PER_CH = 16.
- Sub-module sample_fifo: parameterised width/depth, first-word fall-through, with full, empty and level outputs. Instantiated once.
- Divider, slot counter and shift register stay in audio_i2s_tx.

Test Plan:
- Reset and divider timing (BCLK_DIV=2): release reset, no samples -> bclk period 4 clk, lrck toggles every 16 BCLK, sdata=0, underrun pulses once per 128 clk.
- Single sample: push 0x8001 before the first slot-0 entry -> slots 1..16 sdata = 1,0..0,1; slots 17..31 = 1,0..0 (R[15..1]); next slot 0 = 1 (R[0]); one pop, fifo_level 1->0.
- Underrun hold: push 0x1234, then nothing for 3 frames -> every frame repeats 0x1234 on L/R; underrun pulses on each of the 3 slot-0 entries.
- Overflow (FIFO_DEPTH=4): push 5 samples back-to-back mid-frame -> fifo_level=4, one overflow pulse, 5th sample absent from the serial stream.
- Simultaneous push/pop at full: sample_valid asserted in the slot-0 pop cycle with level 4 -> write accepted, level stays 4, no overflow.
- Async reset mid-frame: assert reset at slot 9 -> bclk=1, lrck=1, sdata=0, fifo_level=0 without a clk edge; after release, timing restarts per scenario 1.
- Stereo build (AUDIO_I2S_TX_STEREO_EN): sample=0x00FF, sample_r=0xFF00 -> L and R serialized independently.
